// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - default FIR geometry, coefficients and accumulator sizing helpers
package fir_pkg;

    localparam int DEF_NB_DATA = 4;
    localparam int DEF_N_TAPS  = 4;

    // Q3 taps h[0]..h[3] = {1,3,3,1}/8, h[0] in the most significant slice
    localparam logic [DEF_N_TAPS*DEF_NB_DATA-1:0] DEF_COEF = 16'h1331;

    function automatic int acc_width(input int nb_data, input int n_taps);
        return 2 * nb_data + $clog2(n_taps);
    endfunction

    function automatic int lut_width(input int nb_data, input int n_taps);
        return nb_data + $clog2(n_taps);
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_NB_DATA, DEF_N_TAPS);

endpackage

// File: rtl/fir_da_lut.sv
// rtl/fir_da_lut.sv - distributed-arithmetic partial sum of the taps whose current bit is set
module fir_da_lut
    import fir_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter logic [N_TAPS*NB_DATA-1:0] COEF = DEF_COEF,
    parameter int LUT_W   = lut_width(NB_DATA, N_TAPS)
) (
    input  logic [N_TAPS-1:0]       tap_bits,
    output logic signed [LUT_W-1:0] part_sum
);

    always_comb begin
        part_sum = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            if (tap_bits[k]) begin
                part_sum = part_sum
                         + LUT_W'($signed(COEF[(N_TAPS-1-k)*NB_DATA +: NB_DATA]));
            end
        end
    end

endmodule

// File: rtl/fir.sv
// rtl/fir.sv - bit-serial DA FIR, one sample per NB_DATA-cycle frame; FIR_SAT_EN selects clamping over wrap
module fir
    import fir_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter logic [N_TAPS*NB_DATA-1:0] COEF = DEF_COEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic signed [NB_DATA-1:0] i_data,
    output logic                      o_busy,
    output logic signed [NB_DATA-1:0] o_data
);

    localparam int ACC_W = acc_width(NB_DATA, N_TAPS);
    localparam int LUT_W = lut_width(NB_DATA, N_TAPS);
    localparam int PH_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NB_DATA - 1);

    logic [PH_W-1:0]           phase;
    logic signed [NB_DATA-1:0] cap;
    logic signed [NB_DATA-1:0] dline [N_TAPS];
    logic signed [ACC_W-1:0]   acc;

    logic                      frame_end;
    logic                      cap_en;
    logic [N_TAPS-1:0]         tap_bits;
    logic signed [LUT_W-1:0]   part_sum;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [NB_DATA-1:0] y_out;

    assign frame_end = (phase == PH_LAST);
    assign cap_en    = (phase == '0);
    assign o_busy    = ~frame_end;

    // Bit slice of the whole delay line at the weight currently being processed
    always_comb begin
        tap_bits = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            tap_bits[k] = dline[k][phase];
        end
    end

    fir_da_lut #(
        .NB_DATA (NB_DATA),
        .N_TAPS  (N_TAPS),
        .COEF    (COEF),
        .LUT_W   (LUT_W)
    ) u_lut (
        .tap_bits (tap_bits),
        .part_sum (part_sum)
    );

    // Phase 0 restarts the sum; the sign weight is subtracted on the last phase
    always_comb begin
        term     = ACC_W'(part_sum) <<< phase;
        acc_next = (cap_en ? '0 : acc) + (frame_end ? -term : term);
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (NB_DATA - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(1 << (NB_DATA - 1)));

    logic signed [ACC_W-1:0] y_full;

    always_comb begin
        y_full = acc_next >>> (NB_DATA - 1);
        if (y_full > Y_MAX) begin
            y_out = NB_DATA'(Y_MAX);
        end else if (y_full < Y_MIN) begin
            y_out = NB_DATA'(Y_MIN);
        end else begin
            y_out = NB_DATA'(y_full);
        end
    end
`else
    // Floor division by 2^(NB_DATA-1) then wrap is just a bit slice
    always_comb begin
        y_out = acc_next[NB_DATA-1 +: NB_DATA];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            phase  <= '0;
            cap    <= '0;
            acc    <= '0;
            o_data <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
                dline[k] <= '0;
            end
        end else begin
            phase <= frame_end ? '0 : phase + PH_W'(1);
            acc   <= acc_next;
            if (cap_en) begin
                cap <= i_data;
            end
            if (frame_end) begin
                o_data   <= y_out;
                dline[0] <= cap;
                for (int k = 1; k < N_TAPS; k++) begin
                    dline[k] <= dline[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_fir.sv
// tb/tb_fir.sv - directed and random checks of fir, plus an overflow instance with COEF {4,4,4,4}
module tb_fir;

    logic              tb_clk;
    logic              i_rst;
    logic signed [3:0] i_data;
    logic              o_busy;
    logic signed [3:0] o_data;
    logic              ov_busy;
    logic signed [3:0] ov_data;

    int n_tests = 0;
    int n_fail  = 0;

    fir dut (
        .i_clk  (tb_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .o_busy (o_busy),
        .o_data (o_data)
    );

    fir #(.COEF(16'h4444)) dut_ov (
        .i_clk  (tb_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .o_busy (ov_busy),
        .o_data (ov_data)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered and left at edge+1 in phase 0; i_data is scrambled after capture
    task automatic run_frame(input logic signed [3:0] x);
        i_data = x;
        @(posedge tb_clk);
        #1;
        i_data = ~x;
        repeat (3) @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        @(posedge tb_clk);
        @(posedge tb_clk);
        #1;
        i_rst = 1'b1;
    endtask

    function automatic logic signed [31:0] model_y(input int s);
        int y;
        y = s >>> 3;
`ifdef FIR_SAT_EN
        if (y > 7) y = 7;
        if (y < -8) y = -8;
`else
        y = ((y + 8) & 15) - 8;
`endif
        return y;
    endfunction

    int h [4] = '{1, 3, 3, 1};
    int hist [4];
    int acc_m;
    logic signed [31:0] exp_prev;
    logic signed [3:0] xr;

    initial begin
        i_rst  = 1'b0;
        i_data = 4'sd0;
        @(posedge tb_clk);
        #1;
        check("rst_o_data", o_data, 0);
        check("rst_o_busy", o_busy, 1);
        check("rst_ov_data", ov_data, 0);
        @(posedge tb_clk);
        #1;
        i_rst = 1'b1;

        // o_busy cadence after release: high for cycles 0..2, low at cycle 3
        check("busy_c0", o_busy, 1);
        for (int c = 1; c < 4; c++) begin
            @(posedge tb_clk);
            #1;
            check($sformatf("busy_c%0d", c), o_busy, (c == 3) ? 0 : 1);
        end
        @(posedge tb_clk);
        #1;
        check("busy_wrap_c4", o_busy, 1);
        check("first_out_zero", o_data, 0);

        // Impulse -8: output lags the sample by one frame
        do_reset();
        run_frame(-4'sd8);
        check("imp_f0", o_data, 0);
        run_frame(4'sd0);
        check("imp_y0", o_data, -1);
        run_frame(4'sd0);
        check("imp_y1", o_data, -3);
        run_frame(4'sd0);
        check("imp_y2", o_data, -3);
        run_frame(4'sd0);
        check("imp_y3", o_data, -1);
        run_frame(4'sd0);
        check("imp_y4", o_data, 0);

        // Step of 7 on both instances; overflow instance wraps or clamps
        do_reset();
        run_frame(4'sd7);
        run_frame(4'sd7);
        check("step_y0", o_data, 0);
        check("ov_y0", ov_data, 3);
        run_frame(4'sd7);
        check("step_y1", o_data, 3);
        check("ov_y1", ov_data, 7);
        run_frame(4'sd7);
        check("step_y2", o_data, 6);
        run_frame(4'sd7);
        check("step_y3", o_data, 7);
        run_frame(4'sd7);
        check("step_y4", o_data, 7);
`ifdef FIR_SAT_EN
        check("ov_steady_a", ov_data, 7);
        run_frame(4'sd7);
        check("ov_steady_b", ov_data, 7);
`else
        check("ov_steady_a", ov_data, -2);
        run_frame(4'sd7);
        check("ov_steady_b", ov_data, -2);
`endif

        // Mid-frame reset: outputs clear at once and history is gone afterwards
        @(posedge tb_clk);
        @(posedge tb_clk);
        #1;
        i_rst = 1'b0;
        #1;
        check("midrst_o_data", o_data, 0);
        check("midrst_o_busy", o_busy, 1);
        @(posedge tb_clk);
        @(posedge tb_clk);
        #1;
        check("midrst_hold", o_data, 0);
        i_rst = 1'b1;
        run_frame(-4'sd8);
        check("post_rst_f0", o_data, 0);
        run_frame(4'sd0);
        check("post_rst_y0", o_data, -1);
        run_frame(4'sd0);
        check("post_rst_y1", o_data, -3);

        // Constant inputs
        do_reset();
        for (int f = 0; f < 6; f++) run_frame(-4'sd8);
        check("const_m8_a", o_data, -8);
        run_frame(-4'sd8);
        check("const_m8_b", o_data, -8);
        for (int f = 0; f < 5; f++) run_frame(4'sd0);
        check("const_zero", o_data, 0);

        // Random samples against the arithmetic model
        do_reset();
        hist     = '{0, 0, 0, 0};
        exp_prev = 0;
        for (int i = 0; i < 1024; i++) begin
            xr = 4'($urandom_range(0, 15));
            run_frame(xr);
            check($sformatf("rand_%0d", i), o_data, exp_prev);
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'(xr);
            acc_m = 0;
            for (int k = 0; k < 4; k++) acc_m += h[k] * hist[k];
            exp_prev = model_y(acc_m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir.md
FIR -- requirements
Module: fir

Interface
REQ-001 Parameter NB_DATA, default 4: sample width in bits, signed two's complement, in and out.
REQ-002 Parameter N_TAPS, default 4: number of filter taps.
REQ-003 Parameter COEF, default from fir_pkg {1,3,3,1}: packed N_TAPS x NB_DATA signed coefficients in Q(NB_DATA-1) fraction format, h[0] first.
REQ-004 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_data  input  NB_DATA  signed input sample x[n].
REQ-007 o_busy  output  1  high while the DUT is processing; low for exactly one cycle per frame (frame boundary).
REQ-008 o_data  output  NB_DATA  signed registered filter output y[n].

Function
REQ-009 Frame = NB_DATA cycles, phase counter 0..NB_DATA-1, wraps to 0; o_busy SHALL be low only when phase == NB_DATA-1.
REQ-010 Source updates i_data at the edge where o_busy is low; DUT SHALL capture i_data at the rising edge ending phase 0 of each frame (one sample per frame).
REQ-011 Sample captured in frame n SHALL be processed bit-serially, LSB first, one bit per cycle during frame n+1 (distributed arithmetic over the N_TAPS delay line).
REQ-012 Bit at weight NB_DATA-1 (sign) SHALL be subtracted, all other bits added, each shifted by bit weight.
REQ-013 Result y[n] = floor(sum h[k]*x[n-k] / 2^(NB_DATA-1)), full-precision accumulator width 2*NB_DATA+clog2(N_TAPS); no intermediate overflow.
REQ-014 o_data SHALL update only at the edge ending phase NB_DATA-1 of frame n+1 and hold y[n] for one full frame; latency 2*NB_DATA-1 cycles from capture edge.
REQ-015 Delay-line history SHALL shift once per frame; taps before first sample read as 0.
REQ-016 i_data changes outside the capture edge SHALL have no effect.

Reset
REQ-017 While i_rst low: phase = 0, o_busy = 1, o_data = 0, delay line, capture and accumulator registers = 0.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately and clear history; no partial result reaches o_data.
REQ-019 After release, first o_busy low at cycle NB_DATA-1; first non-reset output at cycle 2*NB_DATA-1.

Configuration
REQ-020 Macro FIR_SAT_EN defined: final result outside [-2^(NB_DATA-1), 2^(NB_DATA-1)-1] SHALL clamp to the nearest bound.
REQ-021 FIR_SAT_EN undefined: result SHALL wrap (keep low NB_DATA bits).

Structure
REQ-022 Package fir_pkg SHALL hold default NB_DATA, N_TAPS, default COEF and accumulator-width function/constant.
REQ-023 Sub-module fir_da_lut SHALL compute the combinational partial sum of COEF selected by the N_TAPS current bits; fir holds counter, delay line, accumulator, output register.

Verification
REQ-024 Reset: i_rst low mid-frame -> o_data = 0, o_busy = 1 same cycle; o_busy low first at cycle 3 after release (NB_DATA=4).
REQ-025 Impulse: x = -8 then zeros -> o_data sequence -1, -3, -3, -1, 0, one value per frame.
REQ-026 Step: x = 7 sustained -> 0, 3, 6, 7, 7...
REQ-027 Constant x = -8 -> steady -8; constant 0 -> 0.
REQ-028 Overflow: COEF = {4,4,4,4}, x = 7 sustained -> steady 7 with FIR_SAT_EN, -2 without.
REQ-029 Random 1024 samples vs. golden model, one check per frame at o_busy low -> zero mismatches.
